// File: rtl/input_event_arbiter.sv
// Front-panel input conditioner: synchronise, debounce and edge-detect each
// channel, then serialise rising edges through a round-robin valid/ready port.
module input_event_arbiter #(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] stable_state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              overrun_clr,
    output logic              evt_overrun
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_w;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] stable_q, stable_d;
    logic [NUM_CH-1:0] rise_q, rise_d;

    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] take_vec;
    logic [NUM_CH-1:0] ovr_set;

    logic              evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic              load;
    logic              found;
    logic [CH_W-1:0]   grant_idx;

    // First requester at or after ptr, wrapping; MSB of result is "found".
    function automatic logic [CH_W:0] rr_pick(
        input logic [NUM_CH-1:0] req,
        input logic [CH_W-1:0]   ptr
    );
        logic [CH_W:0] r;
        int            idx;
        r = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(ptr) + off) % NUM_CH;
            if (!r[CH_W] && req[idx]) begin
                r = {1'b1, CH_W'(idx)};
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= async_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (sync_w[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = stable_d & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
            rise_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign load = !evt_valid_q || evt_ready;
    assign {found, grant_idx} = rr_pick(pending_q, ptr_q);

    // A rise coinciding with the load of its own channel re-arms pending.
    always_comb begin
        take_vec = '0;
        if (load && found) begin
            take_vec[grant_idx] = 1'b1;
        end
        pending_d = (pending_q & ~take_vec) | rise_q;
        ovr_set   = rise_q & pending_q & ~take_vec;
        overrun_d = (overrun_clr ? '0 : overrun_q) | ovr_set;
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        ptr_d       = ptr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_ch_d = grant_idx;
                ptr_d    = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign stable_state = stable_q;
    assign evt_valid    = evt_valid_q;
    assign evt_ch       = evt_ch_q;
    assign evt_overrun  = |overrun_q;

endmodule

// File: tb/tb_input_event_arbiter.sv
// Directed bench for input_event_arbiter: timing, debounce, round-robin,
// overrun and stall behaviour with hand-derived expectations.
module tb_input_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] async_in = '0;
    logic       evt_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [3:0] stable_state;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_overrun;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         ev_q[$];
    int         ev_t[$];
    logic [3:0] stable_or;

    input_event_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .async_in    (async_in),
        .stable_state(stable_state),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .overrun_clr (overrun_clr),
        .evt_overrun (evt_overrun)
    );

    always #5 clk = ~clk;

    // Sample at the current negedge, then advance one cycle.
    task automatic collect(input int n);
        for (int k = 0; k < n; k++) begin
            if (evt_valid && evt_ready) begin
                ev_q.push_back(int'(evt_ch));
                ev_t.push_back(cyc);
            end
            stable_or |= stable_state;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_log();
        ev_q.delete();
        ev_t.delete();
        stable_or = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        async_in = '0;
        evt_ready = 1'b0;
        overrun_clr = 1'b0;
        collect(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        async_in = 4'b1111;
        evt_ready = 1'b1;
        collect(3);
        n_cmp++;
        if (stable_state !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_stable: got %b expected 0000", stable_state);
        end
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b expected 0", evt_valid);
        end
        n_cmp++;
        if (evt_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset_overrun: got %b expected 0", evt_overrun);
        end
        rst_n = 1'b1;
        clear_log();
        collect(30);
        n_cmp++;
        if (ev_q.size() !== 4) begin
            n_err++;
            $display("FAIL reset_count: got %0d expected 4", ev_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= ev_q.size() || ev_q[k] !== k) begin
                n_err++;
                $display("FAIL reset_order[%0d]: got %0d expected %0d",
                         k, (k < ev_q.size()) ? ev_q[k] : -1, k);
            end
        end
        async_in = '0;
        collect(25);
    endtask

    task automatic test_single_press();
        do_reset();
        async_in = 4'b0100;
        evt_ready = 1'b1;
        clear_log();
        collect(17);
        n_cmp++;
        if (stable_state !== 4'b0000) begin
            n_err++;
            $display("FAIL single_stable17: got %b expected 0000", stable_state);
        end
        collect(1);
        n_cmp++;
        if (stable_state !== 4'b0100) begin
            n_err++;
            $display("FAIL single_stable18: got %b expected 0100", stable_state);
        end
        collect(1);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_valid19: got %b expected 0", evt_valid);
        end
        collect(1);
        n_cmp++;
        if (evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_valid20: got %b expected 1", evt_valid);
        end
        n_cmp++;
        if (evt_ch !== 2'd2) begin
            n_err++;
            $display("FAIL single_ch20: got %0d expected 2", evt_ch);
        end
        collect(1);
        n_cmp++;
        if (evt_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_valid21: got %b expected 0", evt_valid);
        end
        async_in = '0;
        collect(30);
        n_cmp++;
        if (ev_q.size() !== 1) begin
            n_err++;
            $display("FAIL single_release_events: got %0d expected 1", ev_q.size());
        end
        n_cmp++;
        if (stable_state !== 4'b0000) begin
            n_err++;
            $display("FAIL single_release_stable: got %b expected 0000", stable_state);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        evt_ready = 1'b1;
        clear_log();
        async_in = 4'b0010;
        collect(15);
        async_in = '0;
        collect(30);
        n_cmp++;
        if (stable_or !== 4'b0000) begin
            n_err++;
            $display("FAIL glitch_stable: got %b expected 0000", stable_or);
        end
        n_cmp++;
        if (ev_q.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_events: got %0d expected 0", ev_q.size());
        end
        clear_log();
        async_in = 4'b0010;
        collect(16);
        async_in = '0;
        collect(40);
        n_cmp++;
        if (ev_q.size() !== 1 || ev_q[0] !== 1) begin
            n_err++;
            $display("FAIL pulse16_event: got %0d events expected 1 on ch1", ev_q.size());
        end
        n_cmp++;
        if (stable_or !== 4'b0010) begin
            n_err++;
            $display("FAIL pulse16_stable: got %b expected 0010", stable_or);
        end
    endtask

    task automatic test_round_robin();
        int exp3[3];
        do_reset();
        async_in = 4'b1011;
        collect(22);
        async_in = '0;
        evt_ready = 1'b1;
        clear_log();
        collect(30);
        exp3 = '{0, 1, 3};
        n_cmp++;
        if (ev_q.size() !== 3) begin
            n_err++;
            $display("FAIL rr_count: got %0d expected 3", ev_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (k >= ev_q.size() || ev_q[k] !== exp3[k]) begin
                n_err++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d",
                         k, (k < ev_q.size()) ? ev_q[k] : -1, exp3[k]);
            end
        end
        n_cmp++;
        if (ev_t.size() < 3 || ev_t[2] - ev_t[0] !== 2) begin
            n_err++;
            $display("FAIL rr_back_to_back: got span %0d expected 2",
                     (ev_t.size() >= 3) ? ev_t[2] - ev_t[0] : -1);
        end
        clear_log();
        async_in = 4'b0001;
        collect(30);
        async_in = '0;
        collect(25);
        n_cmp++;
        if (ev_q.size() !== 1 || ev_q[0] !== 0) begin
            n_err++;
            $display("FAIL rr_repress0: got %0d events expected 1 on ch0", ev_q.size());
        end
        evt_ready = 1'b0;
        clear_log();
        async_in = 4'b0110;
        collect(22);
        async_in = 4'b0001;
        collect(22);
        evt_ready = 1'b1;
        collect(10);
        exp3 = '{1, 2, 0};
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (k >= ev_q.size() || ev_q[k] !== exp3[k]) begin
                n_err++;
                $display("FAIL rr_wrap[%0d]: got %0d expected %0d",
                         k, (k < ev_q.size()) ? ev_q[k] : -1, exp3[k]);
            end
        end
        async_in = '0;
        collect(25);
    endtask

    task automatic test_overrun();
        do_reset();
        async_in = 4'b0001;
        collect(22);
        async_in = 4'b0011;
        collect(22);
        async_in = 4'b0001;
        collect(22);
        n_cmp++;
        if (evt_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_before: got %b expected 0", evt_overrun);
        end
        async_in = 4'b0011;
        collect(22);
        n_cmp++;
        if (evt_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_set: got %b expected 1", evt_overrun);
        end
        evt_ready = 1'b1;
        clear_log();
        collect(10);
        n_cmp++;
        if (ev_q.size() !== 2 || ev_q[0] !== 0 || ev_q[1] !== 1) begin
            n_err++;
            $display("FAIL ovr_merge: got %0d events expected 2 (ch0, ch1)", ev_q.size());
        end
        n_cmp++;
        if (evt_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_sticky: got %b expected 1", evt_overrun);
        end
        overrun_clr = 1'b1;
        collect(1);
        overrun_clr = 1'b0;
        n_cmp++;
        if (evt_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: got %b expected 0", evt_overrun);
        end
        evt_ready = 1'b0;
        async_in = 4'b0000;
        collect(22);
        async_in = 4'b0001;
        collect(22);
        async_in = 4'b0011;
        collect(22);
        async_in = 4'b0001;
        collect(22);
        async_in = 4'b0011;
        collect(18);
        n_cmp++;
        if (stable_state[1] !== 1'b1 || evt_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_pre_coincide: got stable1=%b ovr=%b expected 1 0",
                     stable_state[1], evt_overrun);
        end
        overrun_clr = 1'b1;
        collect(1);
        overrun_clr = 1'b0;
        n_cmp++;
        if (evt_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_coincide: got %b expected 1", evt_overrun);
        end
    endtask

    task automatic test_stall();
        int exp4[4];
        do_reset();
        async_in = 4'b1000;
        collect(21);
        n_cmp++;
        if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin
            n_err++;
            $display("FAIL stall_offer: got v=%b ch=%0d expected v=1 ch=3", evt_valid, evt_ch);
        end
        async_in = 4'b1111;
        for (int k = 0; k < 25; k++) begin
            collect(1);
            n_cmp++;
            if (evt_valid !== 1'b1 || evt_ch !== 2'd3) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b ch=%0d expected v=1 ch=3",
                         k, evt_valid, evt_ch);
            end
        end
        evt_ready = 1'b1;
        clear_log();
        collect(10);
        exp4 = '{3, 0, 1, 2};
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= ev_q.size() || ev_q[k] !== exp4[k]) begin
                n_err++;
                $display("FAIL stall_drain[%0d]: got %0d expected %0d",
                         k, (k < ev_q.size()) ? ev_q[k] : -1, exp4[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        async_in = 4'b0001;
        collect(22);
        n_cmp++;
        if (evt_valid !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre: got %b expected 1", evt_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (evt_valid !== 1'b0 || stable_state !== 4'b0000) begin
            n_err++;
            $display("FAIL areset_drop: got v=%b stable=%b expected 0 0000",
                     evt_valid, stable_state);
        end
        async_in = '0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        collect(3);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_press();
        test_glitch();
        test_round_robin();
        test_overrun();
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_event_arbiter.md
# input_event_arbiter

Conditions up to NUM_CH asynchronous front-panel inputs (push-buttons, external strobes) and serialises their rising edges into a single event stream for the core logic. Each channel is synchronised, debounced and edge-detected, then held as a pending request. A round-robin arbiter hands one channel index at a time to the consumer over a valid/ready handshake, and lost events are flagged.

## Interface
- NUM_CH, 4: number of input channels, ≥2.
- SYNC_STAGES, 2: synchroniser flops per channel, ≥2.
- DEBOUNCE_CYCLES, 16: consecutive differing synchronised samples required to accept a level change, ≥2.
- CH_W, $clog2(NUM_CH): width of the channel index (derived; not overridden).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk at integration.
- async_in  in  NUM_CH  raw asynchronous inputs, active high.
- stable_state  out  NUM_CH  debounced level per channel.
- evt_valid  out  1  an event is offered on evt_ch.
- evt_ready  in  1  consumer accepts the event when evt_valid is also high.
- evt_ch  out  CH_W  index of the channel whose rising edge is offered.
- overrun_clr  in  1  single-cycle pulse that clears all overrun flags.
- evt_overrun  out  1  sticky OR of per-channel overrun flags.

## Operation
- Reset (rst_n low, asynchronous): all synchroniser flops, stable_state, debounce counters, pending, overrun flags, evt_valid, evt_ch and the round-robin pointer go to 0.
- Synchroniser: per channel, a SYNC_STAGES-deep shift register. sync[i] is the last stage.
- Debounce, per channel, with counter cnt[i] (width $clog2(DEBOUNCE_CYCLES)):
  - sync[i] == stable_state[i]: cnt[i] <= 0.
  - sync[i] != stable_state[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] increments.
  - sync[i] != stable_state[i] and cnt[i] == DEBOUNCE_CYCLES-1: stable_state[i] toggles and cnt[i] <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes stable_state.
- Edge detect: rise[i] is high for one cycle when stable_state[i] goes 0->1. Falling edges produce no event.
- Pending: rise[i] sets pending[i]. Loading channel i into the output register clears pending[i].
  - If rise[i] and a load of channel i happen in the same cycle, pending[i] ends at 1 and no overrun is flagged.
  - If rise[i] arrives while pending[i] is 1 and channel i is not loaded that cycle, overrun[i] is set and the event is merged.
- Overrun: overrun[i] is sticky. overrun_clr clears all flags. If overrun_clr and a new overrun occur in the same cycle, the set wins for that channel. evt_overrun = |overrun.
- Output register and arbiter:
  - The load condition is (!evt_valid || evt_ready).
  - On load, if any pending bit is set, pick the first set pending[k] searching from ptr upward with wrap-around. Then evt_ch <= k, evt_valid <= 1, pending[k] <= 0, ptr <= (k+1) mod NUM_CH.
  - On load with nothing pending, evt_valid <= 0. evt_ch and ptr hold.
  - While evt_valid && !evt_ready, evt_ch and evt_valid are held stable. Offered events are never withdrawn.

## Timing
- Let async_in[i] rise and meet setup before edge 1, and stay high. Then sync[i] is high after edge SYNC_STAGES.
- stable_state[i] rises after edge SYNC_STAGES+DEBOUNCE_CYCLES.
- pending[i] is set one edge later.
- evt_valid rises after edge SYNC_STAGES+DEBOUNCE_CYCLES+2. With defaults this is edge 20.
- Throughput: back-to-back events, one per cycle, while evt_ready is held high and requests are pending.
- Consumer handshake to next offer: 0 extra cycles. The next pending event appears in the cycle after acceptance.
- rst_n asserted mid-offer: evt_valid drops immediately (asynchronously). All pending events and flags are lost.

## Test plan
- Reset: drive async_in=4'b1111 during reset. Require stable_state=0, evt_valid=0, evt_overrun=0 while rst_n=0. After release, exactly 4 events arrive in order 0,1,2,3.
- Single press: async_in[2] rises before edge 1 and evt_ready=1. Require evt_valid high only in the cycle after edge 20, with evt_ch=2, for one cycle. Releasing the input generates no event.
- Glitch rejection: a 15-cycle high pulse on async_in[1] (DEBOUNCE_CYCLES=16) produces no stable_state change and no event. A 16-cycle stable pulse produces one event.
- Round-robin under backpressure: hold evt_ready=0 and make channels 0, 1 and 3 pending. Then assert evt_ready=1. Require grants 0, 1, 3 on consecutive cycles. A new press on channel 0 afterwards is granted after channel 3.
- Overrun: hold evt_ready=0 and press channel 1 twice, with debounced rising edges separated by a release. Require evt_overrun=1 and only one event for channel 1. Pulse overrun_clr and require evt_overrun=0 on the next cycle. A coincident new overrun keeps it at 1.
- Stall stability: with evt_valid=1 and evt_ready=0 for 10 cycles while other channels assert, evt_ch must stay constant throughout.
